fetch_stage: RTL

Instruction-fetch stage of the 3-stage RV32I pipeline. It sits directly upstream of the decode/execute controller. It owns the program counter and drives instruction-memory addressing. It also owns the fetch-to-decode instruction register that the controller decodes. When the controller flags a control transfer, the block inserts NOP bubbles and redirects the PC to the resolved branch/jump target.

---
 rtl/fetch_stage.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, the fetch-to-decode instruction register,
// and inserts NOP bubbles while redirecting after a decoded control transfer.
module fetch_stage #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR     = 32'h0000_0013,
  parameter int unsigned BUBBLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc4_out,
  output logic        valid_out,
  output logic [31:0] bubble_cnt,
  output logic        state_dbg_o,
  output logic [2:0]  hold_cnt_dbg_o
);

  // Handshake: there is no backpressure. Every edge out of reset produces one
  // decode slot; valid_out=1 marks a real fetched word, valid_out=0 a bubble.

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [2:0] HOLD_LOAD = 3'(BUBBLE_CYCLES - 1);
  localparam bit         MULTI_BUBBLE = (BUBBLE_CYCLES > 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] bubble_q, bubble_d;

  logic [31:0] pc_plus4;
  logic [31:0] bubble_inc;

  assign pc_plus4   = pc_q + 32'd4;
  assign bubble_inc = (bubble_q == 32'hFFFF_FFFF) ? bubble_q : bubble_q + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      cnt_q    <= 3'd0;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pc_out_q <= 32'd0;
      pc4_q    <= 32'd0;
      valid_q  <= 1'b0;
      bubble_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      pc4_q    <= pc4_d;
      valid_q  <= valid_d;
      bubble_q <= bubble_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    pc4_d    = pc4_q;
    valid_d  = valid_q;
    bubble_d = bubble_q;

    unique case (state_q)
      RUN: begin
        if (stall_in) begin
          // Discard the word fetched this cycle; a not-taken transfer keeps pc
          // so the fall-through is refetched rather than skipped.
          instr_d  = NOP_INSTR;
          valid_d  = 1'b0;
          bubble_d = bubble_inc;
          if (br_taken) begin
            pc_d = {br_target[31:2], 2'b00};
          end
          if (MULTI_BUBBLE) begin
            state_d = HOLD;
            cnt_d   = HOLD_LOAD;
          end
        end else begin
          instr_d  = imem_rdata;
          pc_out_d = pc_q;
          pc4_d    = pc_plus4;
          valid_d  = 1'b1;
          pc_d     = pc_plus4;
        end
      end
      HOLD: begin
        // stall_in/br_taken are deliberately ignored: the controller only sees
        // bubbles here, so any pulse cannot belong to a real transfer.
        instr_d  = NOP_INSTR;
        valid_d  = 1'b0;
        bubble_d = bubble_inc;
        cnt_d    = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign imem_addr      = pc_q;
  assign instr_out      = instr_q;
  assign pc_out         = pc_out_q;
  assign pc4_out        = pc4_q;
  assign valid_out      = valid_q;
  assign bubble_cnt     = bubble_q;
  assign state_dbg_o    = state_q;
  assign hold_cnt_dbg_o = cnt_q;

endmodule
